// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU select codes and divider FSM states
package alu_pkg;

  localparam logic [4:0] ALU_DIV  = 5'b01110;
  localparam logic [4:0] ALU_DIVU = 5'b01111;
  localparam logic [4:0] ALU_REM  = 5'b10000;
  localparam logic [4:0] ALU_REMU = 5'b10001;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between the execute stage and the divider
interface div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [4:0]            div_sel;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, div_sel, op1, op2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, div_sel, op1, op2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration (shift in next dividend bit, trial subtract)
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] rem_ext;
  logic [W:0] diff;
  logic       fits;

  // rem_i < divisor, so the shifted value fits W+1 bits and diff[W] is the borrow
  assign rem_ext = {rem_i, quo_i[W-1]};
  assign diff    = rem_ext - {1'b0, dvs_i};
  assign fits    = ~diff[W];
  assign rem_o   = fits ? diff[W-1:0] : rem_ext[W-1:0];
  assign quo_o   = {quo_i[W-2:0], fits};
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative signed/unsigned divider, one quotient bit per cycle
module div_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  div_state_e    state_q, state_d;
  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [W-1:0]  step_rem, step_quo;

  logic accept, in_signed, in_rem, a_neg, b_neg;

  div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign in_signed = (bus.div_sel == ALU_DIV) || (bus.div_sel == ALU_REM);
  assign in_rem    = (bus.div_sel == ALU_REM) || (bus.div_sel == ALU_REMU);
  assign a_neg     = in_signed && bus.op1[W-1];
  assign b_neg     = in_signed && bus.op2[W-1];
  assign accept    = ((state_q == DIV_IDLE) || (state_q == DIV_DONE)) &&
                     bus.start && !bus.flush && is_div_op(bus.div_sel);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DIV_DONE;
          if (is_rem_q) result_d = neg_rem_q ? -step_rem : step_rem;
          else          result_d = neg_quo_q ? -step_quo : step_quo;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    if (accept) begin
      is_rem_d = in_rem;
      if (bus.op2 == '0) begin
        state_d  = DIV_DONE;
        result_d = in_rem ? bus.op1 : '1;
      end else if (in_signed && (bus.op1 == MIN_NEG) && (bus.op2 == '1)) begin
        state_d  = DIV_DONE;
        result_d = in_rem ? '0 : MIN_NEG;
      end else begin
        state_d   = DIV_CALC;
        rem_d     = '0;
        quo_d     = a_neg ? -bus.op1 : bus.op1;
        dvs_d     = b_neg ? -bus.op2 : bus.op2;
        cnt_d     = '0;
        neg_quo_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
      end
    end

    // flush beats everything, including a result landing on the same edge
    if (bus.flush) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.busy   = (state_q == DIV_CALC);
  assign bus.done   = (state_q == DIV_DONE);
  assign bus.result = result_q;
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port div_sel, input, 5, operation code using the execute-stage ALU select encoding: 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
REQ-006 SHALL have port op1, input, DATA_WIDTH, dividend.
REQ-007 SHALL have port op2, input, DATA_WIDTH, divisor.
REQ-008 SHALL have port flush, input, 1, pipeline flush that aborts any operation in progress.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-011 SHALL have port result, output, DATA_WIDTH, quotient or remainder.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL accept start only in IDLE or DONE with flush low and div_sel one of the four codes; any other start SHALL be ignored.
REQ-014 SHALL latch op1, op2 and div_sel on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-015 Normal case: SHALL enter CALC and perform exactly DATA_WIDTH restoring-division iterations, one per cycle, on unsigned magnitudes.
REQ-016 After the last iteration, SHALL enter DONE; done SHALL rise DATA_WIDTH+1 cycles after the accepting edge, i.e. cycle 33 for 32 bits.
REQ-017 Divide-by-zero (op2 = 0): SHALL bypass CALC and go to DONE the next cycle; DIV/DIVU SHALL return all ones and REM/REMU SHALL return op1.
REQ-018 Signed overflow (DIV/REM, op1 = 0x80000000, op2 = 0xFFFFFFFF): SHALL bypass CALC; DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-019 Signed operations: SHALL negate the quotient when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-020 busy SHALL be high exactly while the state is CALC; done SHALL be high exactly while the state is DONE (one cycle).
REQ-021 DONE SHALL return to IDLE next cycle unless a new start is accepted in that cycle, giving back-to-back operation.
REQ-022 result SHALL hold its last value until the next done; it SHALL be 0 after reset.
REQ-023 flush in any state SHALL force IDLE on the next edge with no done pulse.
REQ-024 flush asserted with start in the same cycle: flush SHALL win and the start SHALL be dropped.
REQ-025 SHALL guarantee op1 - op1 / op2 * op2 == remainder for every non-special case.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy = 0, done = 0, result = 0 and clear the internal quotient, remainder and count registers.
REQ-027 Reset mid-operation SHALL discard the operation; no done SHALL follow reset release.

Structure
REQ-028 The 5-bit ALU select constants and the FSM state enum SHALL live in the shared package alu_pkg, used by both alu and div_unit.
REQ-029 The single-iteration shift/subtract step SHALL be a combinational sub-module div_step (remainder in, quotient in, divisor in -> remainder out, quotient out).
REQ-030 The iteration counter SHALL be $clog2(DATA_WIDTH)+1 bits wide and SHALL NOT wrap during an operation.

Verification
REQ-031 SHALL cover: DIV 100 / 7, start at cycle 0 -> busy cycles 1-32, done at cycle 33, result 14; REM same operands -> result 2.
REQ-032 SHALL cover: REM 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD (-3).
REQ-033 SHALL cover: DIVU 5 / 0 -> done at cycle 1, result 0xFFFFFFFF; REMU 5 / 0 -> result 5.
REQ-034 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> done at cycle 1, result 0x80000000; REM same operands -> result 0.
REQ-035 SHALL cover: flush at cycle 10 of DIVU 1000 / 3 -> busy low from cycle 11, no done; a new start then returns 333.
REQ-036 SHALL cover: rst_n low at cycle 5 mid-op -> outputs 0 immediately; start in DONE cycle with DIVU 9 / 3 -> second done 33 cycles later, result 3.
